exp_align_ctrl: RTL

Exponent-alignment controller for the floating-point adder datapath. It accepts two operands (8-bit exponent plus 24-bit mantissa with hidden bit), selects the larger exponent, and computes the exponent difference. It loads that difference into the existing down counter, then right-shifts the smaller mantissa one bit per cycle until the counter's `Ediff` value reaches zero. Its outputs feed the mantissa adder stage.

---
 rtl/exp_align_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/exp_align_ctrl.sv
// Exponent-alignment controller for the FP adder datapath.
// Picks the larger-exponent operand, loads the clamped exponent difference
// into an external down counter and right-shifts the smaller mantissa one
// bit per cycle until the counter reports zero.
module exp_align_ctrl #(
    parameter int unsigned MAX_SHIFT = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  exp_a,
    input  logic [7:0]  exp_b,
    input  logic [23:0] mant_a,
    input  logic [23:0] mant_b,
    output logic        busy,
    output logic        done,
    output logic        swapped,
    output logic [7:0]  exp_out,
    output logic [23:0] mant_big,
    output logic [25:0] mant_small,
    output logic        sticky,
    output logic [7:0]  cnt_entrada,
    output logic        cnt_load,
    output logic        cnt_countDown,
    input  logic [7:0]  cnt_Ediff
);

    localparam logic [7:0] MaxShift = 8'(MAX_SHIFT);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    state_e      state_q, state_d;
    logic        swapped_q;
    logic [7:0]  exp_q;
    logic [7:0]  diff_q;
    logic [23:0] mant_big_q;
    logic [25:0] mant_small_q;
    logic        sticky_q;
    logic        a_ge_b;
    logic        accept;

    assign a_ge_b = (exp_a >= exp_b);
    assign accept = (state_q == StIdle) && start;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and counter handshake; load and countDown are decoded from
    // mutually exclusive states so they can never overlap.
    always_comb begin
        state_d       = state_q;
        cnt_load      = 1'b0;
        cnt_countDown = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                cnt_load = 1'b1;
                state_d  = StShift;
            end
            StShift: begin
                if (cnt_Ediff != 8'd0) begin
                    cnt_countDown = 1'b1;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Operand capture on accepted start, then one alignment shift per countDown
    always_ff @(posedge clk) begin
        if (rst) begin
            swapped_q    <= 1'b0;
            exp_q        <= 8'd0;
            diff_q       <= 8'd0;
            mant_big_q   <= 24'd0;
            mant_small_q <= 26'd0;
            sticky_q     <= 1'b0;
        end else if (accept) begin
            sticky_q <= 1'b0;
            if (a_ge_b) begin
                swapped_q    <= 1'b0;
                exp_q        <= exp_a;
                diff_q       <= exp_a - exp_b;
                mant_big_q   <= mant_a;
                mant_small_q <= {mant_b, 2'b00};
            end else begin
                swapped_q    <= 1'b1;
                exp_q        <= exp_b;
                diff_q       <= exp_b - exp_a;
                mant_big_q   <= mant_b;
                mant_small_q <= {mant_a, 2'b00};
            end
        end else if (cnt_countDown) begin
            mant_small_q <= mant_small_q >> 1;
            sticky_q     <= sticky_q | mant_small_q[0];
        end
    end

    // Status and result outputs
    always_comb begin
        busy        = (state_q != StIdle);
        done        = (state_q == StDone);
        swapped     = swapped_q;
        exp_out     = exp_q;
        mant_big    = mant_big_q;
        mant_small  = mant_small_q;
        sticky      = sticky_q;
        cnt_entrada = (diff_q > MaxShift) ? MaxShift : diff_q;
    end

endmodule
